// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//   Conditions the board push-buttons before the core uses them. Each key is
//   synchronised, debounced and turned into a clean active-high level. The
//   block also produces single-cycle pulses for an accepted press, an
//   accepted release, and a long press.
//
//   Parameters
//     NUM_KEYS          number of independent key channels
//     DEBOUNCE_CYCLES   consecutive stable cycles needed to accept a change
//                       (must be >= 2)
//     LONG_PRESS_CYCLES cycles spent pressed before key_hold fires
//                       (must be > DEBOUNCE_CYCLES)
//
//   Ports
//     clk          system clock
//     rst          synchronous, active-high reset
//     key_n        raw buttons, active-low, asynchronous to clk
//     key_level    debounced state, 1 = pressed
//     key_press    one-cycle pulse on an accepted press
//     key_release  one-cycle pulse on an accepted release
//     key_hold     one-cycle pulse once a press has lasted LONG_PRESS_CYCLES
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// key_conditioner_ch
//   Single key channel: a two-flop synchroniser followed by the debounce and
//   long-press FSM. All outputs are registered.
//
//   Ports
//     i_clk, i_rst   clock and synchronous active-high reset
//     i_key_n        raw active-low button
//     o_key_level    debounced level, 1 = pressed
//     o_key_press    press pulse
//     o_key_release  release pulse
//     o_key_hold     long-press pulse (at most once per press)
// ---------------------------------------------------------------------------
module key_conditioner_ch #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_key_level,
    output logic o_key_press,
    output logic o_key_release,
    output logic o_key_hold
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_hold;

    // The hold counter stops at HOLD_MAX. Because it does not wrap, key_hold
    // can fire at most once per press; the counter is cleared only on entry
    // to PRESSED from PRESS_PEND.
    logic              w_hold_run;
    logic              w_hold_fire;

    assign w_hold_run  = (r_hold_cnt != HOLD_MAX);
    assign w_hold_fire = (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // The synchroniser resets to "released". A key that is still
            // held when reset ends is therefore seen as a fresh press.
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= ST_RELEASED;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_sync1   <= i_key_n;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;

            case (r_state)
                ST_RELEASED: begin
                    if (!r_sync2) begin
                        r_state   <= ST_PRESS_PEND;
                        r_deb_cnt <= DEB_ONE;
                    end else begin
                        r_deb_cnt <= '0;
                    end
                end

                ST_PRESS_PEND: begin
                    if (r_sync2) begin
                        // Bounce: drop back without any pulse.
                        r_state   <= ST_RELEASED;
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == DEB_MAX) begin
                        r_state    <= ST_PRESSED;
                        r_deb_cnt  <= '0;
                        r_hold_cnt <= '0;
                        r_level    <= 1'b1;
                        r_press    <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                    end
                end

                ST_PRESSED: begin
                    if (w_hold_run) begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                        r_hold     <= w_hold_fire;
                    end
                    if (r_sync2) begin
                        r_state   <= ST_RELEASE_PEND;
                        r_deb_cnt <= DEB_ONE;
                    end
                end

                ST_RELEASE_PEND: begin
                    if (!r_sync2) begin
                        // Release bounce: return to PRESSED, keep the level
                        // and the hold count so the long press still fires.
                        r_state   <= ST_PRESSED;
                        r_deb_cnt <= '0;
                        if (w_hold_run) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                            r_hold     <= w_hold_fire;
                        end
                    end else if (r_deb_cnt == DEB_MAX) begin
                        // The hold counter is frozen on this cycle. That
                        // keeps key_hold from landing in the same cycle as
                        // key_release.
                        r_state   <= ST_RELEASED;
                        r_deb_cnt <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + DEB_ONE;
                        if (w_hold_run) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                            r_hold     <= w_hold_fire;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_RELEASED;
                    r_deb_cnt <= '0;
                end
            endcase
        end
    end

    assign o_key_level   = r_level;
    assign o_key_press   = r_press;
    assign o_key_release = r_release;
    assign o_key_hold    = r_hold;

endmodule

module key_conditioner #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_hold
);

    // Channels share nothing except clock and reset.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_conditioner_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_ch (
            .i_clk         (clk),
            .i_rst         (rst),
            .i_key_n       (key_n[g]),
            .o_key_level   (key_level[g]),
            .o_key_press   (key_press[g]),
            .o_key_release (key_release[g]),
            .o_key_hold    (key_hold[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//   Directed bench for key_conditioner with DEBOUNCE_CYCLES=4 and
//   LONG_PRESS_CYCLES=12. Inputs change 1 ns after a rising edge. Outputs are
//   sampled at that same point.
//
//   k counts rising edges from the moment an input changes, and the first
//   such edge is k=1. The expected timing is:
//     - key_press and key_release appear at k = 1 + 6 = 7 (E+2+D edges);
//     - key_hold appears 12 edges after the press, at k = 19.
//
//   Every sample compares the packed vector {level, press, release, hold}.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int NK = 4;

    logic          clk;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_hold;

    int n_cmp;
    int n_err;

    key_conditioner #(
        .NUM_KEYS          (NK),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (12)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_hold    (key_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] got;
        rst   = 1'b1;
        key_n = 4'b1111;
        for (int k = 1; k <= 3; k++) begin
            tick();
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_hold k=%0d got=%h exp=%h", k, got, 16'h0000);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_idle k=%0d got=%h exp=%h", k, got, 16'h0000);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [15:0] got, exp;
        key_n[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k >= 7) ? 4'b0001 : 4'b0000, (k == 7) ? 4'b0001 : 4'b0000,
                   4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_press k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        key_n[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k < 7) ? 4'b0001 : 4'b0000, 4'b0000,
                   (k == 7) ? 4'b0001 : 4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_release k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] got, exp;
        // Pattern: low 3, high 1, low 2, then high for a while.
        for (int k = 1; k <= 15; k++) begin
            key_n[1] = !(k <= 3 || k == 5 || k == 6);
            tick();
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== 16'h0000) begin
                n_err++;
                $display("FAIL bounce_glitch k=%0d got=%h exp=%h", k, got, 16'h0000);
            end
        end
        key_n[1] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k >= 7) ? 4'b0010 : 4'b0000, (k == 7) ? 4'b0010 : 4'b0000,
                   4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bounce_press k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        key_n[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k < 7) ? 4'b0010 : 4'b0000, 4'b0000,
                   (k == 7) ? 4'b0010 : 4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bounce_release k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_long_press();
        logic [15:0] got, exp;
        key_n[2] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp = {(k >= 7) ? 4'b0100 : 4'b0000, (k == 7) ? 4'b0100 : 4'b0000,
                   4'b0000, (k == 19) ? 4'b0100 : 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL long_press k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        key_n[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp = {(k < 7) ? 4'b0100 : 4'b0000, 4'b0000,
                   (k == 7) ? 4'b0100 : 4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL long_release k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_multi_release_bounce();
        logic [15:0] got, exp;
        key_n[0] = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            // Key 3 goes high for two cycles, which is shorter than the
            // debounce window.
            key_n[3] = (k == 11 || k == 12);
            tick();
            exp = {(k >= 7) ? 4'b1001 : 4'b0000, (k == 7) ? 4'b1001 : 4'b0000,
                   4'b0000, (k == 19) ? 4'b1001 : 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL multi_press k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        key_n[0] = 1'b1;
        key_n[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k < 7) ? 4'b1001 : 4'b0000, 4'b0000,
                   (k == 7) ? 4'b1001 : 4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL multi_release k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [15:0] got, exp;
        logic        lvl;
        key_n[0] = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            // The edge at k=11 resets the block. The synchroniser captures
            // the low key again at k=12, so the press returns at k=18.
            rst = (k == 11);
            tick();
            lvl = (k >= 7 && k <= 10) || (k >= 18);
            exp = {lvl ? 4'b0001 : 4'b0000,
                   (k == 7 || k == 18) ? 4'b0001 : 4'b0000,
                   4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_mid k=%0d got=%h exp=%h", k, got, exp);
            end
        end
        rst      = 1'b0;
        key_n[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = {(k < 7) ? 4'b0001 : 4'b0000, 4'b0000,
                   (k == 7) ? 4'b0001 : 4'b0000, 4'b0000};
            got = {key_level, key_press, key_release, key_hold};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_mid_release k=%0d got=%h exp=%h", k, got, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        key_n = 4'b1111;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_multi_release_bounce();
        test_reset_mid_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
